// File: rtl/battle_encounter_ctrl.sv
// Wild-encounter controller: counts grass steps, rolls an LFSR for encounters,
// and sequences OVERWORLD -> INTRO -> BATTLE -> COOLDOWN for the map scroller.
module battle_encounter_ctrl #(
   parameter logic [3:0]  GRASS_INDEX     = 4'd13,
   parameter logic [5:0]  STEP_THRESH     = 6'd32,
   parameter logic [8:0]  ENCOUNTER_PROB  = 9'd64,
   parameter logic [7:0]  INTRO_FRAMES    = 8'd60,
   parameter logic [7:0]  COOLDOWN_FRAMES = 8'd120,
   parameter logic [7:0]  RUN_KEY         = 8'h15,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic [9:0] FrameX,
   input  logic [9:0] FrameY,
   input  logic [3:0] pelette_index,
   output logic [1:0] battle_bit,
   output logic       encounter_pulse,
   output logic [7:0] anim_count,
   output logic [5:0] step_count
);

   localparam int unsigned POS_W  = 10;
   localparam int unsigned STEP_W = 6;
   localparam int unsigned ANIM_W = 8;
   localparam int unsigned LFSR_W = 16;

   typedef enum logic [1:0] {
      ST_OVERWORLD = 2'd0,
      ST_INTRO     = 2'd1,
      ST_BATTLE    = 2'd2,
      ST_COOLDOWN  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [ANIM_W-1:0]   anim_q, anim_d;
   logic                pulse_q, pulse_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [POS_W-1:0]    prev_x_q, prev_y_q;

   logic moved;
   logic step;
   logic roll_hit;

   // Movement detection, grass qualification and the encounter roll on the pre-shift LFSR
   always_comb begin
      moved    = (FrameX != prev_x_q) || (FrameY != prev_y_q);
      step     = moved && (pelette_index == GRASS_INDEX);
      roll_hit = {1'b0, lfsr_q[7:0]} < ENCOUNTER_PROB;
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};
   end

   // Next-state logic for the encounter sequencer and its counters
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      anim_d  = anim_q;
      pulse_d = 1'b0;
      unique case (state_q)
         ST_OVERWORLD: begin
            anim_d = '0;
            if (step) begin
               if (step_q >= STEP_THRESH - 6'd1) begin
                  step_d = '0;
                  if (roll_hit) begin
                     state_d = ST_INTRO;
                     pulse_d = 1'b1;
                  end
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
            end
         end
         ST_INTRO: begin
            if (anim_q == INTRO_FRAMES - 8'd1) begin
               state_d = ST_BATTLE;
               anim_d  = '0;
            end else begin
               anim_d = anim_q + ANIM_W'(1);
            end
         end
         ST_BATTLE: begin
            anim_d = '0;
            if (keycode == RUN_KEY) begin
               state_d = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            if (anim_q == COOLDOWN_FRAMES - 8'd1) begin
               state_d = ST_OVERWORLD;
               anim_d  = '0;
            end else begin
               anim_d = anim_q + ANIM_W'(1);
            end
         end
         default: state_d = ST_OVERWORLD;
      endcase
   end

   // State and counter registers; reset samples the current scroll position
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q  <= ST_OVERWORLD;
         step_q   <= '0;
         anim_q   <= '0;
         pulse_q  <= 1'b0;
         lfsr_q   <= LFSR_SEED;
         prev_x_q <= FrameX;
         prev_y_q <= FrameY;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         anim_q   <= anim_d;
         pulse_q  <= pulse_d;
         lfsr_q   <= lfsr_d;
         prev_x_q <= FrameX;
         prev_y_q <= FrameY;
      end
   end

   assign battle_bit      = state_q;
   assign encounter_pulse = pulse_q;
   assign anim_count      = anim_q;
   assign step_count      = step_q;

endmodule

// File: tb/tb_battle_encounter_ctrl.sv
// Directed bench: one always-hit and one never-hit instance share the same stimulus.
module tb_battle_encounter_ctrl;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode;
   logic [9:0] FrameX, FrameY;
   logic [3:0] pelette_index;

   logic [1:0] a_bit,   b_bit;
   logic       a_pulse, b_pulse;
   logic [7:0] a_anim,  b_anim;
   logic [5:0] a_step,  b_step;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned b_exp = 0;

   always #5 frame_clk = ~frame_clk;

   battle_encounter_ctrl #(.STEP_THRESH(6'd4), .ENCOUNTER_PROB(9'd256)) dut_a (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .FrameX(FrameX), .FrameY(FrameY), .pelette_index(pelette_index),
      .battle_bit(a_bit), .encounter_pulse(a_pulse),
      .anim_count(a_anim), .step_count(a_step));

   battle_encounter_ctrl #(.STEP_THRESH(6'd4), .ENCOUNTER_PROB(9'd0)) dut_b (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .FrameX(FrameX), .FrameY(FrameY), .pelette_index(pelette_index),
      .battle_bit(b_bit), .encounter_pulse(b_pulse),
      .anim_count(b_anim), .step_count(b_step));

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame: optionally move, clock, then check the never-hit instance
   task automatic frame(input bit mv);
      if (mv) FrameX = FrameX + 10'd1;
      @(posedge frame_clk);
      #1;
      if (Reset) b_exp = 0;
      else if (mv && pelette_index == 4'd13) b_exp = (b_exp + 1) % 4;
      chk("b_step", b_step, b_exp);
      chk("b_bit", b_bit, 0);
      chk("b_pulse", b_pulse, 0);
      chk("b_anim", b_anim, 0);
   endtask

   initial begin
      Reset = 1'b1; keycode = 8'h00; FrameX = '0; FrameY = '0; pelette_index = 4'd13;
      frame(1'b0);
      chk("rst_bit", a_bit, 0);
      chk("rst_step", a_step, 0);
      chk("rst_pulse", a_pulse, 0);
      chk("rst_anim", a_anim, 0);
      Reset = 1'b0;

      // Standing on grass without moving
      for (int i = 0; i < 3; i++) begin
         frame(1'b0);
         chk("static_step", a_step, 0);
      end

      // Moving off grass
      pelette_index = 4'd2;
      for (int i = 0; i < 3; i++) begin
         frame(1'b1);
         chk("offgrass_step", a_step, 0);
      end
      pelette_index = 4'd13;

      // Three qualifying steps, the fourth triggers the encounter
      for (int i = 1; i <= 3; i++) begin
         frame(1'b1);
         chk("count_step", a_step, i);
         chk("count_bit", a_bit, 0);
      end
      frame(1'b1);
      chk("hit_bit", a_bit, 1);
      chk("hit_pulse", a_pulse, 1);
      chk("hit_step", a_step, 0);
      chk("hit_anim", a_anim, 0);

      // INTRO: run key held from frame 10 on, including the transition frame
      for (int i = 1; i <= 60; i++) begin
         keycode = (i >= 10) ? 8'h15 : 8'h00;
         frame(1'b1);
         chk("intro_pulse", a_pulse, 0);
         if (i < 60) begin
            chk("intro_bit", a_bit, 1);
            chk("intro_anim", a_anim, i);
         end else begin
            chk("battle_bit", a_bit, 2);
            chk("battle_anim", a_anim, 0);
         end
      end

      // Run key seen while in BATTLE flees
      frame(1'b1);
      chk("flee_bit", a_bit, 3);
      chk("flee_anim", a_anim, 0);
      keycode = 8'h00;

      // COOLDOWN ignores grass movement
      for (int i = 1; i <= 120; i++) begin
         frame(1'b1);
         chk("cool_step", a_step, 0);
         if (i < 120) begin
            chk("cool_bit", a_bit, 3);
            chk("cool_anim", a_anim, i);
         end else begin
            chk("back_bit", a_bit, 0);
            chk("back_anim", a_anim, 0);
         end
      end

      // Counting resumes in OVERWORLD
      for (int i = 1; i <= 3; i++) begin
         frame(1'b1);
         chk("resume_step", a_step, i);
      end
      frame(1'b1);
      chk("hit2_bit", a_bit, 1);
      chk("hit2_pulse", a_pulse, 1);

      // Reset mid-INTRO with the run key pressed
      keycode = 8'h15;
      for (int i = 0; i < 30; i++) frame(1'b0);
      chk("mid_bit", a_bit, 1);
      chk("mid_anim", a_anim, 30);
      Reset = 1'b1;
      frame(1'b0);
      chk("rst2_bit", a_bit, 0);
      chk("rst2_anim", a_anim, 0);
      chk("rst2_step", a_step, 0);
      chk("rst2_pulse", a_pulse, 0);
      Reset = 1'b0;
      keycode = 8'h00;
      frame(1'b1);
      chk("post_rst_step", a_step, 1);
      chk("post_rst_bit", a_bit, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
